// File: rtl/mem_integrity_pkg.sv
// Shared helpers for the memory integrity scoreboard.
package mem_integrity_pkg;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

  // Saturating +1 for counters up to 32 bits wide
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_integrity_rdpipe.sv
// RD_LAT-deep delay line for captured read entries.
// Async reset, sync flush, pass-through when RD_LAT is 0.
module mem_integrity_rdpipe
  import mem_integrity_pkg::*;
#(
  parameter int  RD_LAT = 1,
  parameter type T      = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  T     i_d,
  output T     o_q
);

  generate
    if (RD_LAT == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, i_flush};
      assign o_q = i_d;
    end else begin : g_pipe
      T r_q [RD_LAT];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < RD_LAT; i++) r_q[i] <= '0;
        end else if (i_flush) begin
          for (int i = 0; i < RD_LAT; i++) r_q[i] <= '0;
        end else begin
          r_q[0] <= i_d;
          for (int i = 1; i < RD_LAT; i++) r_q[i] <= r_q[i-1];
        end
      end

      assign o_q = r_q[RD_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mem_integrity_scoreboard.sv
// Shadow-memory read checker with per-byte valid bits.
// Define MEM_INTEGRITY_ERRLOG_EN to add the first-mismatch log ports.
module mem_integrity_scoreboard
  import mem_integrity_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                chk_en,
  input  logic                write,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                read,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   rdata,
  output logic                err_mismatch,
  output logic                err_uninit,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic [CNT_W-1:0]    uninit_cnt
`ifdef MEM_INTEGRITY_ERRLOG_EN
  ,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_exp,
  output logic [DATA_W-1:0]   err_act
`endif
);

  localparam int NB    = nbytes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
`ifdef MEM_INTEGRITY_ERRLOG_EN
    logic [ADDR_W-1:0] addr;
`endif
    logic [DATA_W-1:0] exp;
    logic [NB-1:0]     vmask;
  } entry_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [NB-1:0]     r_vld [DEPTH];
  logic              r_mis;
  logic              r_uni;
  logic [CNT_W-1:0]  r_mis_cnt;
  logic [CNT_W-1:0]  r_uni_cnt;
  entry_t            w_in;
  entry_t            w_out;
  logic              w_mis;
  logic              w_uni;

  // Data bytes need no reset; the valid bits decide what is compared
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (write && wbe[b]) r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_vld[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_vld[i] <= '0;
    end else if (write) begin
      r_vld[addr] <= r_vld[addr] | wbe;
    end
  end

  always_comb begin
    w_in       = '0;
    w_in.valid = read & chk_en;
    w_in.exp   = r_mem[addr];
    w_in.vmask = r_vld[addr];
`ifdef MEM_INTEGRITY_ERRLOG_EN
    w_in.addr  = addr;
`endif
  end

  mem_integrity_rdpipe #(
    .RD_LAT (RD_LAT),
    .T      (entry_t)
  ) u_rdpipe (
    .clk     (clk),
    .reset   (reset),
    .i_flush (clear),
    .i_d     (w_in),
    .o_q     (w_out)
  );

  always_comb begin
    w_mis = 1'b0;
    w_uni = 1'b0;
    if (w_out.valid) begin
      for (int b = 0; b < NB; b++) begin
        if (!w_out.vmask[b]) begin
          w_uni = 1'b1;
        end else if (rdata[b*8 +: 8] !== w_out.exp[b*8 +: 8]) begin
          w_mis = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mis     <= 1'b0;
      r_uni     <= 1'b0;
      r_mis_cnt <= '0;
      r_uni_cnt <= '0;
    end else if (clear) begin
      r_mis     <= 1'b0;
      r_uni     <= 1'b0;
      r_mis_cnt <= '0;
      r_uni_cnt <= '0;
    end else begin
      r_mis <= w_mis;
      r_uni <= w_uni;
      if (w_mis)
        r_mis_cnt <= CNT_W'(sat_inc(32'(r_mis_cnt), CNT_W));
      if (w_uni)
        r_uni_cnt <= CNT_W'(sat_inc(32'(r_uni_cnt), CNT_W));
    end
  end

  assign err_mismatch = r_mis;
  assign err_uninit   = r_uni;
  assign mismatch_cnt = r_mis_cnt;
  assign uninit_cnt   = r_uni_cnt;

`ifdef MEM_INTEGRITY_ERRLOG_EN
  logic              r_log_vld;
  logic [ADDR_W-1:0] r_log_addr;
  logic [DATA_W-1:0] r_log_exp;
  logic [DATA_W-1:0] r_log_act;

  // Only the first mismatch since reset/clear is kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_log_vld  <= 1'b0;
      r_log_addr <= '0;
      r_log_exp  <= '0;
      r_log_act  <= '0;
    end else if (clear) begin
      r_log_vld  <= 1'b0;
      r_log_addr <= '0;
      r_log_exp  <= '0;
      r_log_act  <= '0;
    end else if (w_mis && !r_log_vld) begin
      r_log_vld  <= 1'b1;
      r_log_addr <= w_out.addr;
      r_log_exp  <= w_out.exp;
      r_log_act  <= rdata;
    end
  end

  assign err_valid = r_log_vld;
  assign err_addr  = r_log_addr;
  assign err_exp   = r_log_exp;
  assign err_act   = r_log_act;
`endif

endmodule

// File: tb/tb_mem_integrity_scoreboard.sv
// Scoreboard bench for mem_integrity_scoreboard (RD_LAT=3, CNT_W=4).
// Byte-level reference model; a monitor pops expectations per edge.
module tb_mem_integrity_scoreboard;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NB   = DW / 8;
  localparam int LAT  = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DEP  = 1 << AW;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          clear  = 1'b0;
  logic          chk_en = 1'b0;
  logic          write  = 1'b0;
  logic [NB-1:0] wbe    = '0;
  logic [DW-1:0] wdata  = '0;
  logic          read   = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] rdata  = '0;
  logic          err_mismatch;
  logic          err_uninit;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] uninit_cnt;
`ifdef MEM_INTEGRITY_ERRLOG_EN
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_act;
`endif

  always #5 clk = ~clk;

  mem_integrity_scoreboard #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (LAT),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .chk_en       (chk_en),
    .write        (write),
    .wbe          (wbe),
    .wdata        (wdata),
    .read         (read),
    .addr         (addr),
    .rdata        (rdata),
    .err_mismatch (err_mismatch),
    .err_uninit   (err_uninit),
    .mismatch_cnt (mismatch_cnt),
`ifdef MEM_INTEGRITY_ERRLOG_EN
    .uninit_cnt   (uninit_cnt),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_exp      (err_exp),
    .err_act      (err_act)
`else
    .uninit_cnt   (uninit_cnt)
`endif
  );

  typedef struct {
    int            due;
    bit            flush;
    bit            mis;
    bit            uni;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    logic [DW-1:0] act;
    logic [NB-1:0] vm;
  } exp_t;

  exp_t          q[$];
  logic [7:0]    m_data [DEP][NB];
  bit            m_vld  [DEP][NB];
  logic [DW-1:0] sched  [int];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;
  bit            done   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h",
               nm, cyc, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] mword(input int a);
    logic [DW-1:0] w;
    for (int b = 0; b < NB; b++) w[b*8 +: 8] = m_data[a][b];
    return w;
  endfunction

  task automatic flush_at(input int d);
    exp_t f;
    while (q.size() > 0 && q[$].due >= d) void'(q.pop_back());
    f = '{due: d, flush: 1'b1, mis: 1'b0, uni: 1'b0,
          a: '0, exp: '0, act: '0, vm: '0};
    q.push_back(f);
    for (int i = 0; i < DEP; i++)
      for (int b = 0; b < NB; b++) m_vld[i][b] = 0;
  endtask

  // One clock of stimulus; the model acts at the edge these inputs hit
  task automatic step(input bit rs, input bit cl, input bit ce,
                      input bit wr, input logic [NB-1:0] be,
                      input logic [DW-1:0] wd, input bit rd,
                      input logic [AW-1:0] a, input logic [DW-1:0] rv);
    int   e;
    exp_t x;
    e = cyc + 1;
    if (rs && !reset) flush_at(cyc);
    reset = rs; clear = cl; chk_en = ce; write = wr;
    wbe = be; wdata = wd; read = rd; addr = a;
    if (sched.exists(e)) begin
      rdata = sched[e];
      sched.delete(e);
    end else begin
      rdata = $urandom;
    end
    if (rs || cl) begin
      flush_at(e);
    end else begin
      if (rd && ce) begin
        x.due = e + LAT; x.flush = 0; x.mis = 0; x.uni = 0;
        x.a = a; x.exp = mword(a); x.act = rv;
        for (int b = 0; b < NB; b++) begin
          x.vm[b] = m_vld[a][b];
          if (!m_vld[a][b]) x.uni = 1;
          else if (rv[b*8 +: 8] !== m_data[a][b]) x.mis = 1;
        end
        q.push_back(x);
        sched[e + LAT] = rv;
      end
      if (wr) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) begin
            m_data[a][b] = wd[b*8 +: 8];
            m_vld[a][b]  = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 1, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be,
                    input logic [DW-1:0] d);
    step(0, 0, 1, 1, be, d, 0, a, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] rv);
    step(0, 0, 1, 0, '0, '0, 1, a, rv);
  endtask

  // Monitor: one expectation set per edge, all-zero flags by default
  initial begin
    int            em, eu, mc, uc;
    bit            lv;
    logic [AW-1:0] la;
    logic [DW-1:0] le, lact;
    logic [NB-1:0] lm;
    exp_t          x;
    mc = 0; uc = 0; lv = 0; la = '0; le = '0; lact = '0; lm = '0;
    while (!done) begin
      @(posedge clk);
      #2;
      em = 0; eu = 0;
      while (q.size() > 0 && q[0].due <= cyc) begin
        x = q.pop_front();
        if (x.flush) begin
          em = 0; eu = 0; mc = 0; uc = 0; lv = 0;
        end else begin
          em = int'(x.mis);
          eu = int'(x.uni);
          if (x.mis && mc < CMAX) mc++;
          if (x.uni && uc < CMAX) uc++;
          if (x.mis && !lv) begin
            lv = 1; la = x.a; le = x.exp; lact = x.act; lm = x.vm;
          end
        end
      end
      chk("err_mismatch", err_mismatch, em);
      chk("err_uninit", err_uninit, eu);
      chk("mismatch_cnt", mismatch_cnt, mc);
      chk("uninit_cnt", uninit_cnt, uc);
`ifdef MEM_INTEGRITY_ERRLOG_EN
      chk("err_valid", err_valid, lv);
      if (lv) begin
        chk("err_addr", err_addr, la);
        chk("err_act", err_act, lact);
        for (int b = 0; b < NB; b++)
          if (lm[b])
            chk("err_exp", err_exp[b*8 +: 8], le[b*8 +: 8]);
      end
`endif
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    step(1, 0, 0, 0, '0, '0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0, 0, '0, '0);
    idle(2);

    wr(4'd3, 4'hF, 32'hDEADBEEF);
    rd(4'd3, 32'hDEADBEEF);
    idle(LAT + 1);
    rd(4'd3, 32'hDEADBEEE);
    idle(LAT + 1);

    wr(4'd5, 4'b0011, 32'h0000_1234);
    rd(4'd5, 32'hFFFF_1234);
    rd(4'd5, 32'hFFFF_1235);
    idle(LAT + 1);

    wr(4'd7, 4'hF, 32'h11);
    step(0, 0, 1, 1, 4'hF, 32'h22, 1, 4'd7, 32'h11);
    wr(4'd7, 4'hF, 32'h11);
    step(0, 0, 1, 1, 4'hF, 32'h22, 1, 4'd7, 32'h22);
    rd(4'd7, 32'h22);
    idle(LAT + 1);

    for (int i = 0; i < DEP; i++) wr(AW'(i), 4'hF, $urandom);
    for (int i = 0; i < 12; i++) begin
      if (i == 5 || i == 6) begin
        step(1, 0, 1, 0, '0, '0, 1, AW'(i), '0);
      end else begin
        a = AW'($urandom_range(0, DEP - 1));
        rd(a, $urandom);
      end
    end
    idle(LAT + 1);

    for (int i = 0; i < DEP; i++) wr(AW'(i), 4'hF, $urandom);
    for (int i = 0; i < 10; i++) begin
      a = AW'($urandom_range(0, DEP - 1));
      if (i == 4) step(0, 1, 1, 0, '0, '0, 1, a, '0);
      else rd(a, ~mword(a));
    end
    idle(LAT + 1);

    wr(4'd0, 4'hF, 32'hA5A5_0001);
    for (int i = 0; i < (1 << CW) + 5; i++) rd(4'd0, 32'h0);
    idle(LAT + 1);

    step(0, 1, 1, 0, '0, '0, 0, '0, '0);
    wr(4'd2, 4'hF, 32'h0202_0202);
    wr(4'd9, 4'hF, 32'h0909_0909);
    rd(4'd2, 32'h0202_0203);
    rd(4'd9, 32'h1909_0909);
    idle(LAT + 2);
    step(0, 1, 1, 0, '0, '0, 0, '0, '0);
    idle(2);

    for (int i = 0; i < 500; i++) begin
      a = AW'($urandom_range(0, DEP - 1));
      v = mword(a);
      if ($urandom_range(0, 1) == 0)
        v = v ^ (32'd1 << $urandom_range(0, DW - 1));
      if ($urandom_range(0, 199) == 0)
        step(1, 0, 1, 0, '0, '0, 0, '0, '0);
      else
        step(0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 7) != 0, 1'($urandom),
             NB'($urandom), $urandom, 1'($urandom), a, v);
    end
    idle(LAT + 3);

    done = 1;
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
